// File: rtl/vseq_pkg.sv
// Shared definitions for the vector op sequencer: FSM states, ALU op codes,
// default geometry and the element ALU function.
package vseq_pkg;

    localparam int VSEQ_NUM_VREGS = 16;
    localparam int VSEQ_VLEN      = 5;
    localparam int VSEQ_DW        = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        EXEC = 2'b10,
        WB   = 2'b11
    } vseq_state_e;

    typedef enum logic [1:0] {
        VOP_ADD = 2'b00,
        VOP_SUB = 2'b01,
        VOP_AND = 2'b10,
        VOP_ORR = 2'b11
    } vseq_op_e;

    // One element operation; arithmetic wraps modulo 2^DW, carry/borrow dropped.
    function automatic logic [VSEQ_DW-1:0] vseq_alu(input vseq_op_e op,
                                                    input logic [VSEQ_DW-1:0] a,
                                                    input logic [VSEQ_DW-1:0] b);
        logic [VSEQ_DW-1:0] y;
        y = '0;
        case (op)
            VOP_ADD: y = a + b;
            VOP_SUB: y = a - b;
            VOP_AND: y = a & b;
            VOP_ORR: y = a | b;
            default: y = '0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/vseq_elem_alu.sv
// Combinational 32-bit element ALU, shared across all elements of a vector
// (the sequencer feeds it one element per cycle).
module vseq_elem_alu
    import vseq_pkg::*;
(
    input  logic [1:0]         op,
    input  logic [VSEQ_DW-1:0] a,
    input  logic [VSEQ_DW-1:0] b,
    output logic [VSEQ_DW-1:0] y
);

    // Decode the op code and compute one element result.
    always_comb begin
        y = vseq_alu(vseq_op_e'(op), a, b);
    end

endmodule

// File: rtl/vector_op_sequencer.sv
// Element-wise vector ALU sequencer. Accepts one instruction, reads both
// source vectors in LOAD, runs one element per cycle through a shared ALU in
// EXEC, then writes the whole destination vector in a single WB cycle.
// Optional feature: define VSEQ_SCALAR_EN to enable vector-scalar mode
// (vs_mode = 1 replaces every B element with the latched scalar_b).
module vector_op_sequencer
    import vseq_pkg::*;
#(
    parameter int NUM_VREGS = VSEQ_NUM_VREGS,
    parameter int VLEN      = VSEQ_VLEN,
    parameter int DW        = VSEQ_DW
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_valid,
    output logic                         start_ready,
    input  logic [1:0]                   op,
    input  logic [$clog2(NUM_VREGS)-1:0] va,
    input  logic [$clog2(NUM_VREGS)-1:0] vb,
    input  logic [$clog2(NUM_VREGS)-1:0] vd,
    input  logic                         vs_mode,
    input  logic [DW-1:0]                scalar_b,
    output logic [$clog2(NUM_VREGS)-1:0] rd_a,
    output logic [$clog2(NUM_VREGS)-1:0] rd_b,
    input  logic [VLEN*DW-1:0]           rd_a_data,
    input  logic [VLEN*DW-1:0]           rd_b_data,
    output logic                         wr_en,
    output logic [$clog2(NUM_VREGS)-1:0] wr_vd,
    output logic [VLEN*DW-1:0]           wr_data,
    output logic                         busy,
    output logic                         done
);

    localparam int AW = $clog2(NUM_VREGS);
    localparam int EW = (VLEN > 1) ? $clog2(VLEN) : 1;
    localparam logic [EW-1:0] LAST_IDX = EW'(VLEN - 1);

    vseq_state_e   state, state_nxt;
    logic [EW-1:0] elem_idx;
    logic          accept;

    // Latched instruction fields; held for the whole operation.
    logic [1:0]    op_q;
    logic [AW-1:0] va_q, vb_q, vd_q;

    // Operand snapshots taken in LOAD make in-place (vd == va/vb) ops safe.
    logic [DW-1:0] a_buf   [VLEN];
    logic [DW-1:0] b_buf   [VLEN];
    logic [DW-1:0] res_buf [VLEN];

    logic [DW-1:0] alu_a, alu_b, alu_y;

`ifdef VSEQ_SCALAR_EN
    logic          mode_q;
    logic [DW-1:0] scalar_q;
`else
    // Scalar-mode ports stay on the interface but have no effect in this build.
    logic unused_scalar;
    assign unused_scalar = ^{vs_mode, scalar_b};
`endif

    assign accept = start_valid & start_ready;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and per-state control decodes.
    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        state_nxt   = state;
        start_ready = 1'b0;
        busy        = 1'b1;
        rd_a        = '0;
        rd_b        = '0;
        wr_en       = 1'b0;
        wr_vd       = '0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start_valid) state_nxt = LOAD;
            end
            LOAD: begin
                rd_a      = va_q;
                rd_b      = vb_q;
                state_nxt = EXEC;
            end
            EXEC: begin
                if (elem_idx == LAST_IDX) state_nxt = WB;
            end
            WB: begin
                wr_en     = 1'b1;
                wr_vd     = vd_q;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Select the current element's operands for the shared ALU.
    always_comb begin
        alu_a = a_buf[elem_idx];
        alu_b = b_buf[elem_idx];
`ifdef VSEQ_SCALAR_EN
        if (mode_q) alu_b = scalar_q;
`endif
    end

    vseq_elem_alu u_alu (
        .op (op_q),
        .a  (alu_a),
        .b  (alu_b),
        .y  (alu_y)
    );

    // Datapath: latch instruction, snapshot operands, step through elements.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            elem_idx <= '0;
            op_q     <= '0;
            va_q     <= '0;
            vb_q     <= '0;
            vd_q     <= '0;
`ifdef VSEQ_SCALAR_EN
            mode_q   <= 1'b0;
            scalar_q <= '0;
`endif
            // NOTE: these buffers are small flop arrays, not RAM, so they are
            // cleared on reset to keep their contents defined afterwards.
            for (int i = 0; i < VLEN; i++) begin
                a_buf[i]   <= '0;
                b_buf[i]   <= '0;
                res_buf[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= op;
                        va_q <= va;
                        vb_q <= vb;
                        vd_q <= vd;
`ifdef VSEQ_SCALAR_EN
                        mode_q   <= vs_mode;
                        scalar_q <= scalar_b;
`endif
                    end
                end
                LOAD: begin
                    for (int i = 0; i < VLEN; i++) begin
                        a_buf[i] <= rd_a_data[i*DW +: DW];
                        b_buf[i] <= rd_b_data[i*DW +: DW];
                    end
                end
                EXEC: begin
                    res_buf[elem_idx] <= alu_y;
                    if (elem_idx == LAST_IDX) elem_idx <= '0;
                    else                      elem_idx <= elem_idx + EW'(1);
                end
                default: ;
            endcase
        end
    end

    // Pack the result buffer onto the write port only during WB; zero otherwise.
    always_comb begin
        wr_data = '0;
        if (state == WB) begin
            for (int i = 0; i < VLEN; i++) wr_data[i*DW +: DW] = res_buf[i];
        end
    end

endmodule

// File: tb/tb_vector_op_sequencer.sv
// Self-checking bench for vector_op_sequencer: a register file driven by the
// DUT, a transaction-level model computing expected results and timing, a
// per-cycle compare process, and directed scenarios with literal expectations.
// Honours VSEQ_SCALAR_EN the same way as the design.
module tb_vector_op_sequencer;
    import vseq_pkg::*;

    localparam int VLEN = 5;
    localparam int DW   = 32;
    localparam int NV   = 16;
    localparam int VW   = VLEN * DW;
`ifdef VSEQ_SCALAR_EN
    localparam bit SCALAR_EN = 1'b1;
`else
    localparam bit SCALAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic [1:0]    op = '0;
    logic [3:0]    va = '0, vb = '0, vd = '0;
    logic          vs_mode = 1'b0;
    logic [DW-1:0] scalar_b = '0;
    logic [3:0]    rd_a, rd_b, wr_vd;
    logic [VW-1:0] rd_a_data, rd_b_data, wr_data;
    logic          wr_en, busy, done;

    always #5 clk = ~clk;

    vector_op_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .op         (op),
        .va         (va),
        .vb         (vb),
        .vd         (vd),
        .vs_mode    (vs_mode),
        .scalar_b   (scalar_b),
        .rd_a       (rd_a),
        .rd_b       (rd_b),
        .rd_a_data  (rd_a_data),
        .rd_b_data  (rd_b_data),
        .wr_en      (wr_en),
        .wr_vd      (wr_vd),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [VW-1:0] pack5(input logic [DW-1:0] e0, e1, e2, e3, e4);
        return {e4, e3, e2, e1, e0};
    endfunction

    // Register file seen by the DUT, written only through the DUT's write port
    // (plus bench preloads).
    logic [VW-1:0] regs [NV];
    logic          pl_en = 1'b0;
    logic [3:0]    pl_idx = '0;
    logic [VW-1:0] pl_val = '0;

    assign rd_a_data = regs[rd_a];
    assign rd_b_data = regs[rd_b];

    always @(posedge clk) begin
        if (wr_en) regs[wr_vd] <= wr_data;
        if (pl_en) regs[pl_idx] <= pl_val;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference result of one whole vector instruction.
    function automatic logic [VW-1:0] model_op(input logic [1:0] o, input logic [VW-1:0] a,
                                               input logic [VW-1:0] b, input logic sm,
                                               input logic [DW-1:0] s);
        logic [VW-1:0] r;
        logic [DW-1:0] x, y;
        r = '0;
        for (int e = 0; e < VLEN; e++) begin
            x = a[e*DW +: DW];
            y = b[e*DW +: DW];
            if (SCALAR_EN && sm) y = s;
            case (o)
                2'd0:    r[e*DW +: DW] = x + y;
                2'd1:    r[e*DW +: DW] = x - y;
                2'd2:    r[e*DW +: DW] = x & y;
                default: r[e*DW +: DW] = x | y;
            endcase
        end
        return r;
    endfunction

    // Transaction model: an accepted instruction occupies the sequencer for
    // VLEN+2 cycles (LOAD, VLEN x EXEC, WB); the last one carries the write.
    logic [VW-1:0] mregs [NV];
    int            m_left = 0;
    logic [3:0]    m_va, m_vb, m_vd;
    logic [VW-1:0] m_data;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = 0;
        end else begin
            if (pl_en) mregs[pl_idx] = pl_val;
            if (m_left > 0) begin
                if (m_left == 1) mregs[m_vd] = m_data;
                m_left--;
            end else if (start_valid) begin
                m_va   = va;
                m_vb   = vb;
                m_vd   = vd;
                m_data = model_op(op, mregs[va], mregs[vb], vs_mode, scalar_b);
                m_left = VLEN + 2;
            end
        end
    end

    // Per-cycle compare of DUT outputs against the model.
    logic exp_wb;
    always @(negedge clk) begin
        if (!reset) begin
            exp_wb = (m_left == 1);
            check("busy",        busy,        m_left > 0);
            check("start_ready", start_ready, m_left == 0);
            check("wr_en",       wr_en,       exp_wb);
            check("done",        done,        exp_wb);
            check("wr_data",     wr_data,     exp_wb ? m_data : '0);
            if (exp_wb) check("wr_vd", wr_vd, m_vd);
            if (m_left == VLEN + 2) begin
                check("rd_a", rd_a, m_va);
                check("rd_b", rd_b, m_vb);
            end
        end
    end

    // Event log for latency and handshake checks.
    int acc_log[$];
    int wb_log[$];
    int n_done = 0;
    int n_wr   = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (start_valid && start_ready) acc_log.push_back(cyc);
            if (wr_en) begin
                wb_log.push_back(cyc);
                n_wr++;
            end
            if (done) n_done++;
        end
    end

    task automatic preload(input logic [3:0] idx, input logic [VW-1:0] val);
        pl_idx = idx;
        pl_val = val;
        pl_en  = 1'b1;
        @(posedge clk); #1;
        pl_en  = 1'b0;
    endtask

    // Present an instruction and wait until it is accepted; keep=1 leaves
    // start_valid high for a following instruction.
    task automatic issue(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d, input logic sm, input logic [DW-1:0] s,
                         input bit keep);
        int k;
        k = 0;
        op = o; va = a; vb = b; vd = d; vs_mode = sm; scalar_b = s;
        start_valid = 1'b1;
        while (!start_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 50) check("issue_timeout", 0, 1);
        @(posedge clk); #1;
        if (!keep) start_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 50) check("idle_timeout", 0, 1);
    endtask

    int d0, w0, na, nw;

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",        busy,        0);
        check("rst_start_ready", start_ready, 1);
        check("rst_wr_en",       wr_en,       0);
        check("rst_done",        done,        0);
        check("rst_rd_a",        rd_a,        0);
        check("rst_rd_b",        rd_b,        0);
        check("rst_wr_vd",       wr_vd,       0);
        check("rst_wr_data",     wr_data,     0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) preload(4'(i), {VLEN{32'hA5A5_0000 | DW'(i)}});

        // 1: ADD v3 = v1 + v2.
        preload(4'd1, pack5(1, 2, 3, 4, 5));
        preload(4'd2, pack5(10, 20, 30, 40, 50));
        d0 = n_done;
        issue(2'b00, 4'd1, 4'd2, 4'd3, 1'b0, '0, 1'b0);
        wait_idle();
        check("t1_result",  regs[3], pack5(11, 22, 33, 44, 55));
        check("t1_latency", wb_log[wb_log.size()-1] - acc_log[acc_log.size()-1], 7);
        check("t1_done",    n_done - d0, 1);

        // 2: SUB with wrap in element 0 only.
        preload(4'd1, pack5(0, 5, 6, 7, 8));
        preload(4'd2, {VLEN{32'd1}});
        issue(2'b01, 4'd1, 4'd2, 4'd3, 1'b0, '0, 1'b0);
        wait_idle();
        check("t2_result", regs[3], pack5(32'hFFFF_FFFF, 4, 5, 6, 7));

        // 3: in-place AND v5 = v5 & v6.
        preload(4'd5, {VLEN{32'hF0F0_F0F0}});
        preload(4'd6, {VLEN{32'hFF00_FF00}});
        issue(2'b10, 4'd5, 4'd6, 4'd5, 1'b0, '0, 1'b0);
        wait_idle();
        check("t3_result", regs[5], {VLEN{32'hF000_F000}});

        // 4: back-to-back ORR with start_valid held high throughout.
        preload(4'd1, pack5(1, 2, 3, 4, 5));
        preload(4'd2, pack5(10, 20, 30, 40, 50));
        d0 = n_done;
        issue(2'b11, 4'd1, 4'd2, 4'd9, 1'b0, '0, 1'b1);
        issue(2'b11, 4'd5, 4'd6, 4'd10, 1'b0, '0, 1'b0);
        wait_idle();
        na = acc_log.size();
        nw = wb_log.size();
        check("t4_result_a", regs[9],  pack5(11, 22, 31, 44, 55));
        check("t4_result_b", regs[10], {VLEN{32'hFF00_FF00}});
        check("t4_gap",      acc_log[na-1] - wb_log[nw-2], 1);
        check("t4_done",     n_done - d0, 2);

        // 6: vector-scalar ADD (vector-vector when the feature is compiled out).
        issue(2'b00, 4'd1, 4'd2, 4'd8, 1'b1, 32'd100, 1'b0);
        wait_idle();
        check("t6_result", regs[8], SCALAR_EN ? pack5(101, 102, 103, 104, 105)
                                              : pack5(11, 22, 33, 44, 55));

        // 5: reset in the middle of EXEC aborts without a write.
        w0 = n_wr;
        issue(2'b00, 4'd1, 4'd2, 4'd7, 1'b0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("t5_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check("t5_busy",        busy,        0);
        check("t5_start_ready", start_ready, 1);
        check("t5_wr_en",       wr_en,       0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("t5_no_write",  n_wr, w0);
        check("t5_v7_kept",   regs[7], {VLEN{32'hA5A5_0007}});

        // Whole register file against the model.
        for (int i = 0; i < NV; i++) check($sformatf("regfile_v%0d", i), regs[i], mregs[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
